// File: rtl/score_keeper_pkg.sv
// Shared types and helpers for the score keeper: FSM states, BCD points table, one-digit BCD add.
package score_keeper_pkg;

    typedef enum logic [1:0] {eIdle, eAdd, eLevel, eLost} score_state_e;

    // Points per clear for n = 0..4+, index 4 covers every n >= 4
    localparam logic [4:0][15:0] points_bcd_c = {16'h1200, 16'h0300, 16'h0100, 16'h0040, 16'h0000};

    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        if (s > 5'd9) begin
            return {1'b1, s[3:0] + 4'd6};
        end
        return s;
    endfunction

endpackage

// File: rtl/score_keeper_bcd_add.sv
// Combinational ripple BCD adder over digits_p digits with carry in/out.
// Zero latency, no flow control.
module bcd_add
    import score_keeper_pkg::*;
#(
    parameter int digits_p = 6
) (
    input  logic [4*digits_p-1:0] a_i,
    input  logic [4*digits_p-1:0] b_i,
    input  logic                  cin_i,
    output logic [4*digits_p-1:0] sum_o,
    output logic                  cout_o
);

    always_comb begin
        logic [digits_p:0] c;
        logic [4:0]        dig;
        c      = '0;
        dig    = '0;
        sum_o  = '0;
        c[0]   = cin_i;
        for (int i = 0; i < digits_p; i++) begin
            dig              = bcd_digit_add(a_i[4*i +: 4], b_i[4*i +: 4], c[i]);
            sum_o[4*i +: 4]  = dig[3:0];
            c[i+1]           = dig[4];
        end
        cout_o = c[digits_p];
    end

endmodule

// File: rtl/score_keeper.sv
// BCD score / line / level keeper with level-dependent gravity tick; one accepted clear keeps busy_o high level+2 cycles, clears arriving while busy are dropped.
// Optional SCORE_KEEPER_SOFT_DROP_EN adds soft_drop_i, which forces the gravity period to min_period_p.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int height_p          = 32,
    parameter int score_digits_p    = 6,
    parameter int lines_per_level_p = 10,
    parameter int max_level_p       = 15,
    parameter int base_period_p     = 50000000,
    parameter int period_step_p     = 3000000,
    parameter int min_period_p      = 5000000
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [$clog2(height_p)-1:0]   line_elimination_i,
    input  logic                          line_elimination_v_i,
    input  logic                          lose_i,
    input  logic                          restart_i,
`ifdef SCORE_KEEPER_SOFT_DROP_EN
    input  logic                          soft_drop_i,
`endif
    output logic [4*score_digits_p-1:0]   score_o,
    output logic [15:0]                   lines_o,
    output logic [3:0]                    level_o,
    output logic                          gravity_tick_o,
    output logic                          busy_o
);

    localparam int nw_c = $clog2(height_p);
    localparam int sw_c = 4*score_digits_p;

    score_state_e       state_q, state_d;
    logic [sw_c-1:0]    score_q, score_d;
    logic [15:0]        lines_q, lines_d;
    logic [3:0]         level_q, level_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [sw_c-1:0]    pts_q, pts_d;
    logic [nw_c-1:0]    n_q, n_d;
    logic [4:0]         rep_q, rep_d;
    logic [31:0]        grav_q, grav_d;

    logic [2:0]         pts_idx;
    logic [sw_c-1:0]    add_sum;
    logic               add_cout;
    logic [16:0]        lines_sum;
    logic [15:0]        cnt_sum;
    logic signed [31:0] per_raw;
    logic [31:0]        per_lvl;
    logic [31:0]        eff_period;
    logic               tick;

    assign pts_idx = (line_elimination_i > nw_c'(3)) ? 3'd4 : 3'(line_elimination_i);

    bcd_add #(.digits_p(score_digits_p)) u_add (
        .a_i    (score_q),
        .b_i    (pts_q),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    assign lines_sum = {1'b0, lines_q} + 17'(n_q);
    assign cnt_sum   = cnt_q + 16'(n_q);

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lines_d = lines_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        pts_d   = pts_q;
        n_d     = n_q;
        rep_d   = rep_q;
        unique case (state_q)
            eIdle: begin
                if (lose_i) begin
                    state_d = eLost;
                end else if (line_elimination_v_i && (line_elimination_i != '0)) begin
                    pts_d   = sw_c'(points_bcd_c[pts_idx]);
                    n_d     = line_elimination_i;
                    rep_d   = {1'b0, level_q} + 5'd1;
                    state_d = eAdd;
                end
            end
            eAdd: begin
                // Once the top digit carries out the score pins at all nines
                score_d = add_cout ? {score_digits_p{4'h9}} : add_sum;
                rep_d   = rep_q - 5'd1;
                if (rep_q == 5'd1) begin
                    state_d = eLevel;
                end
            end
            eLevel: begin
                lines_d = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
                if (cnt_sum >= 16'(lines_per_level_p)) begin
                    cnt_d   = cnt_sum - 16'(lines_per_level_p);
                    level_d = (level_q == 4'(max_level_p)) ? level_q : level_q + 4'd1;
                end else begin
                    cnt_d   = cnt_sum;
                end
                state_d = eIdle;
            end
            eLost: begin
                state_d = eLost;
            end
            default: state_d = eIdle;
        endcase
        if (restart_i) begin
            state_d = eIdle;
            score_d = '0;
            lines_d = '0;
            level_d = '0;
            cnt_d   = '0;
            rep_d   = '0;
        end
    end

    // Signed intermediate so a large level drives the difference negative and clamps
    assign per_raw = base_period_p - $signed({28'd0, level_q}) * period_step_p;
    assign per_lvl = (per_raw < min_period_p) ? 32'(min_period_p) : per_raw;

`ifdef SCORE_KEEPER_SOFT_DROP_EN
    logic soft_q;
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            soft_q <= 1'b0;
        end else begin
            soft_q <= soft_drop_i;
        end
    end
    assign eff_period = soft_q ? 32'(min_period_p) : per_lvl;
`else
    assign eff_period = per_lvl;
`endif

    // >= rather than == so a period that shrinks under a running count fires at once
    assign tick = (state_q != eLost) && (grav_q >= eff_period - 32'd1);

    always_comb begin
        if (restart_i || (state_d == eLost) || (level_d != level_q) || tick) begin
            grav_d = '0;
        end else begin
            grav_d = grav_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= eIdle;
            score_q <= '0;
            lines_q <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            pts_q   <= '0;
            n_q     <= '0;
            rep_q   <= '0;
            grav_q  <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            lines_q <= lines_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pts_q   <= pts_d;
            n_q     <= n_d;
            rep_q   <= rep_d;
            grav_q  <= grav_d;
        end
    end

    assign score_o        = score_q;
    assign lines_o        = lines_q;
    assign level_o        = level_q;
    assign gravity_tick_o = tick;
    assign busy_o         = (state_q == eAdd) || (state_q == eLevel);

endmodule

// File: tb/tb_score_keeper.sv
// Randomized scoreboard bench for score_keeper with a decimal-arithmetic reference model.
// Busy episodes and gravity tick intervals are checked by a free-running negedge monitor.
module tb_score_keeper;

    localparam int BASE = 20;
    localparam int STEP = 3;
    localparam int MINP = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  n_i;
    logic        v_i;
    logic        lose_i;
    logic        restart_i;
`ifdef SCORE_KEEPER_SOFT_DROP_EN
    logic        soft_i;
`endif
    logic [23:0] score_o;
    logic [15:0] lines_o;
    logic [3:0]  level_o;
    logic        tick_o;
    logic        busy_o;

    always #5 clk = ~clk;

    score_keeper #(
        .height_p(32), .score_digits_p(6), .lines_per_level_p(10), .max_level_p(15),
        .base_period_p(BASE), .period_step_p(STEP), .min_period_p(MINP)
    ) dut (
        .clk_i                (clk),
        .reset_i              (rst_n),
        .line_elimination_i   (n_i),
        .line_elimination_v_i (v_i),
        .lose_i               (lose_i),
        .restart_i            (restart_i),
`ifdef SCORE_KEEPER_SOFT_DROP_EN
        .soft_drop_i          (soft_i),
`endif
        .score_o              (score_o),
        .lines_o              (lines_o),
        .level_o              (level_o),
        .gravity_tick_o       (tick_o),
        .busy_o               (busy_o)
    );

    typedef struct {
        logic [23:0] score;
        int          lines;
        int          level;
        int          busy;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         m_score, m_lines, m_level, m_cnt;
    int         gc = 1;
    bit         gclr = 1'b0;
    bit         gchk = 1'b1;
    int         bl = 0;
    logic [3:0] plev = 4'd0;

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int points(input int n);
        if (n >= 4) return 1200;
        case (n)
            1: return 40;
            2: return 100;
            3: return 300;
            default: return 0;
        endcase
    endfunction

    function automatic int period(input int lvl);
        int p;
        p = BASE - lvl*STEP;
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_score = 0;
        m_lines = 0;
        m_level = 0;
        m_cnt   = 0;
    endtask

    // Drive one clear and, if it will be accepted, predict the finished update
    task automatic issue(input int n);
        exp_t x;
        n_i = 5'(n);
        v_i = 1'b1;
        if (n > 0) begin
            x.busy  = m_level + 2;
            m_score = m_score + points(n) * (m_level + 1);
            if (m_score > 999999) m_score = 999999;
            m_lines = (m_lines + n > 65535) ? 65535 : m_lines + n;
            m_cnt   = m_cnt + n;
            if (m_cnt >= 10) begin
                m_cnt = m_cnt - 10;
                if (m_level < 15) m_level++;
            end
            x.score = to_bcd(m_score);
            x.lines = m_lines;
            x.level = m_level;
            sb.push_back(x);
        end
        step();
        v_i = 1'b0;
    endtask

    task automatic drop(input int n);
        n_i = 5'(n);
        v_i = 1'b1;
        step();
        v_i = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_o === 1'b1 && k < 200) begin
            step();
            k++;
        end
        if (busy_o !== 1'b0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: busy_o=%b after %0d cycles, required 0", busy_o, k);
        end
    endtask

    always @(negedge clk) begin
        if (busy_o === 1'b1) begin
            bl++;
        end else if (bl > 0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_update: busy episode of %0d cycles, required none", bl);
            end else begin
                e = sb.pop_front();
                check("upd_score", score_o, e.score);
                check("upd_lines", lines_o, e.lines);
                check("upd_level", level_o, e.level);
                check("upd_busy_len", bl, e.busy);
            end
            bl = 0;
        end
        if (rst_n !== 1'b1 || gclr || !gchk || level_o !== plev) begin
            gc   = 1;
            gclr = 1'b0;
        end else begin
            gc++;
        end
        if (tick_o === 1'b1 && gchk && rst_n === 1'b1) begin
            check("tick_interval", gc, period(int'(level_o)));
            gc = 0;
        end
        plev = level_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int n;
        rst_n     = 1'b0;
        n_i       = '0;
        v_i       = 1'b0;
        lose_i    = 1'b0;
        restart_i = 1'b0;
`ifdef SCORE_KEEPER_SOFT_DROP_EN
        soft_i    = 1'b0;
`endif
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (8) step();

        // Reset asserted mid-count
        rst_n = 1'b0;
        #1;
        check("rst_score", score_o, 0);
        check("rst_lines", lines_o, 0);
        check("rst_level", level_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_tick", tick_o, 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (45) step();

        issue(1);
        wait_idle();
        check("n1_score", score_o, 24'h000040);
        check("n1_lines", lines_o, 1);
        check("n1_level", level_o, 0);

        repeat (9) begin
            issue(1);
            wait_idle();
            repeat (2) step();
        end
        check("lvl1_level", level_o, 1);
        repeat (40) step();

        issue(4);
        wait_idle();
        check("n4_score", score_o, 24'h002800);
        check("n4_lines", lines_o, 14);

        for (int i = 0; i < 150; i++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
            issue(n);
            if (n > 0) begin
                if ($urandom_range(0, 3) == 0) drop(int'($urandom_range(1, 31)));
                wait_idle();
            end
            repeat ($urandom_range(0, 25)) step();
        end

        repeat (60) begin
            issue(4);
            wait_idle();
        end
        check("sat_score", score_o, 24'h999999);
        check("sat_level", level_o, 15);
        issue(4);
        drop(4);
        wait_idle();
        repeat (30) step();

        // Lose raised during an update: update finishes, then freeze
        issue(3);
        lose_i = 1'b1;
        gchk   = 1'b0;
        wait_idle();
        repeat (3) step();
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) drop(2);
            else step();
            if (tick_o === 1'b1) ticks++;
        end
        check("lost_ticks", ticks, 0);
        check("lost_score", score_o, to_bcd(m_score));
        check("lost_lines", lines_o, m_lines);
        check("lost_busy", busy_o, 0);

        lose_i    = 1'b0;
        restart_i = 1'b1;
        gclr      = 1'b1;
        gchk      = 1'b1;
        model_reset();
        step();
        restart_i = 1'b0;
        check("rs_score", score_o, 0);
        check("rs_lines", lines_o, 0);
        check("rs_level", level_o, 0);
        repeat (45) step();
        issue(1);
        wait_idle();
        check("rs_n1_score", score_o, 24'h000040);

`ifdef SCORE_KEEPER_SOFT_DROP_EN
        gchk  = 1'b0;
        ticks = 0;
        while (tick_o !== 1'b1 && ticks < 40) begin
            step();
            ticks++;
        end
        check("soft_sync_tick", tick_o, 1);
        repeat (11) step();
        soft_i = 1'b1;
        step();
        check("soft_tick", tick_o, 1);
        soft_i = 1'b0;
        gclr   = 1'b1;
        gchk   = 1'b1;
        repeat (30) step();
`endif

        repeat (5) step();
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
